// File: rtl/rst_seq_ctrl.sv
// ---------------------------------------------------------------------------
// rst_seq_ctrl
//   Reset sequencer for N_CH downstream reset domains. When started, it holds
//   every domain in reset for HOLD_CYC cycles. It then releases channel 0,
//   channel 1 and so on, spaced STAGGER_CYC cycles apart. After the last
//   release it runs for RUN_CYC cycles, then re-asserts reset for one cycle.
//   In periodic mode the HOLD..REASSERT round repeats up to MAX_ROUNDS times
//   (0 = until aborted). Otherwise the sequencer parks in DONE.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high master reset
//   start      in   1      begin a sequence (sampled in IDLE and DONE only)
//   abort      in   1      force every channel into reset and return to IDLE
//   ch_rst     out  N_CH   per-domain reset, active-high
//   running    out  1      high while every ch_rst bit is low
//   done       out  1      high while in DONE
//   round_cnt  out  8      rounds completed since last start (wraps)
//   cyc_cnt    out  CNT_W  cycles spent in the current state
//
// Every output is a flop. Each output register is loaded from the next-state
// view of the sequencer, so the outputs line up with the state register and
// there is no input-to-output combinational path.
// ---------------------------------------------------------------------------
module rst_seq_ctrl #(
    parameter int unsigned N_CH          = 4,
    parameter int unsigned HOLD_CYC      = 10,
    parameter int unsigned STAGGER_CYC   = 2,
    parameter int unsigned RUN_CYC       = 45,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned MODE_PERIODIC = 0,
    parameter int unsigned MAX_ROUNDS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [N_CH-1:0]   ch_rst,
    output logic              running,
    output logic              done,
    output logic [7:0]        round_cnt,
    output logic [CNT_W-1:0]  cyc_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HOLD     = 3'd1,
        ST_RELEASE  = 3'd2,
        ST_RUN      = 3'd3,
        ST_REASSERT = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    // A zero-length HOLD or RUN phase is stretched to one cycle.
    localparam int unsigned HOLD_LEN = (HOLD_CYC == 0) ? 1 : HOLD_CYC;
    localparam int unsigned RUN_LEN  = (RUN_CYC == 0) ? 1 : RUN_CYC;
    localparam int unsigned REL_LEN  = (N_CH - 1) * STAGGER_CYC + 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_LEN - 1);
    localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(REL_LEN - 1);
    localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(RUN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t            state_r;
    state_t            state_next_s;
    logic [CNT_W-1:0]  cyc_cnt_r;
    logic [CNT_W-1:0]  cnt_next_s;
    logic [7:0]        round_cnt_r;
    logic [7:0]        round_next_s;
    logic [N_CH-1:0]   ch_rst_r;
    logic [N_CH-1:0]   ch_rst_next_s;
    logic              running_r;
    logic              running_next_s;
    logic              done_r;
    logic              done_next_s;
    logic              another_round_s;

    // IDLE and DONE have no natural end, so their counter saturates instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNT_W'(1);
        end
        return r;
    endfunction

    // Decide whether the round just completed should be followed by another round.
    always_comb begin
        if (MODE_PERIODIC != 32'd0) begin
            another_round_s = (MAX_ROUNDS == 32'd0) ||
                              ((32'(round_cnt_r) + 32'd1) < MAX_ROUNDS);
        end else begin
            another_round_s = 1'b0;
        end
    end

    // Next-state, cycle counter and round counter; abort overrides everything else.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cyc_cnt_r;
        round_next_s = round_cnt_r;
        if (abort) begin
            state_next_s = ST_IDLE;
            cnt_next_s   = CNT_ZERO;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_next_s = ST_HOLD;
                        cnt_next_s   = CNT_ZERO;
                        round_next_s = 8'd0;
                    end else begin
                        cnt_next_s = sat_inc(cyc_cnt_r);
                    end
                end
                ST_HOLD: begin
                    if (cyc_cnt_r == HOLD_LAST) begin
                        state_next_s = ST_RELEASE;
                        cnt_next_s   = CNT_ZERO;
                    end else begin
                        cnt_next_s = cyc_cnt_r + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (cyc_cnt_r == REL_LAST) begin
                        state_next_s = ST_RUN;
                        cnt_next_s   = CNT_ZERO;
                    end else begin
                        cnt_next_s = cyc_cnt_r + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (cyc_cnt_r == RUN_LAST) begin
                        state_next_s = ST_REASSERT;
                        cnt_next_s   = CNT_ZERO;
                    end else begin
                        cnt_next_s = cyc_cnt_r + CNT_W'(1);
                    end
                end
                ST_REASSERT: begin
                    round_next_s = round_cnt_r + 8'd1;
                    cnt_next_s   = CNT_ZERO;
                    if (another_round_s) begin
                        state_next_s = ST_HOLD;
                    end else begin
                        state_next_s = ST_DONE;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                    cnt_next_s   = CNT_ZERO;
                end
            endcase
        end
    end

    // Output values for the upcoming cycle, derived from the next state and count.
    always_comb begin
        ch_rst_next_s  = {N_CH{1'b1}};
        running_next_s = 1'b0;
        done_next_s    = 1'b0;
        case (state_next_s)
            ST_RELEASE: begin
                // Channel i is released once the count reaches i*STAGGER_CYC and stays released.
                for (int i = 0; i < int'(N_CH); i++) begin
                    ch_rst_next_s[i] = (cnt_next_s < CNT_W'(32'(i) * STAGGER_CYC));
                end
                running_next_s = (cnt_next_s == REL_LAST);
            end
            ST_RUN: begin
                ch_rst_next_s  = {N_CH{1'b0}};
                running_next_s = 1'b1;
            end
            ST_DONE: begin
                done_next_s = 1'b1;
            end
            default: begin
                ch_rst_next_s = {N_CH{1'b1}};
            end
        endcase
    end

    // Sequencer state, cycle counter and round counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cyc_cnt_r   <= CNT_ZERO;
            round_cnt_r <= 8'd0;
        end else begin
            state_r     <= state_next_s;
            cyc_cnt_r   <= cnt_next_s;
            round_cnt_r <= round_next_s;
        end
    end

    // Registered channel resets and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_rst_r  <= {N_CH{1'b1}};
            running_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            ch_rst_r  <= ch_rst_next_s;
            running_r <= running_next_s;
            done_r    <= done_next_s;
        end
    end

    assign ch_rst    = ch_rst_r;
    assign running   = running_r;
    assign done      = done_r;
    assign round_cnt = round_cnt_r;
    assign cyc_cnt   = cyc_cnt_r;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rst_seq_ctrl
//   Drives three sequencer instances from a shared set of inputs:
//   - u_d0 uses the default one-shot configuration.
//   - u_d1 is periodic with 3 rounds and no stagger.
//   - u_d2 has a single channel, runs unlimited rounds, uses zero-length
//     phases and a 4-bit counter.
//   A timeline model computes the expected outputs for every instance.
//   Directed steps reproduce the documented scenarios, and a randomized
//   stretch follows.
// ---------------------------------------------------------------------------
module tb_rst_seq_ctrl;

    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic abort;

    always #5 clk = ~clk;

    logic [3:0]  ch0, ch1;
    logic [0:0]  ch2;
    logic        run0, run1, run2;
    logic        dn0, dn1, dn2;
    logic [7:0]  rc0, rc1, rc2;
    logic [15:0] cc0, cc1;
    logic [3:0]  cc2;

    rst_seq_ctrl u_d0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .ch_rst(ch0), .running(run0), .done(dn0), .round_cnt(rc0), .cyc_cnt(cc0)
    );

    rst_seq_ctrl #(
        .N_CH(4), .HOLD_CYC(3), .STAGGER_CYC(0), .RUN_CYC(5), .CNT_W(16),
        .MODE_PERIODIC(1), .MAX_ROUNDS(3)
    ) u_d1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .ch_rst(ch1), .running(run1), .done(dn1), .round_cnt(rc1), .cyc_cnt(cc1)
    );

    rst_seq_ctrl #(
        .N_CH(1), .HOLD_CYC(0), .STAGGER_CYC(1), .RUN_CYC(0), .CNT_W(4),
        .MODE_PERIODIC(1), .MAX_ROUNDS(0)
    ) u_d2 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .ch_rst(ch2), .running(run2), .done(dn2), .round_cnt(rc2), .cyc_cnt(cc2)
    );

    logic [7:0]  o_ch   [NI];
    logic        o_run  [NI];
    logic        o_done [NI];
    logic [7:0]  o_rc   [NI];
    logic [15:0] o_cyc  [NI];

    assign o_ch[0] = {4'b0000, ch0};
    assign o_ch[1] = {4'b0000, ch1};
    assign o_ch[2] = {7'b0000000, ch2};
    assign o_run[0] = run0;
    assign o_run[1] = run1;
    assign o_run[2] = run2;
    assign o_done[0] = dn0;
    assign o_done[1] = dn1;
    assign o_done[2] = dn2;
    assign o_rc[0] = rc0;
    assign o_rc[1] = rc1;
    assign o_rc[2] = rc2;
    assign o_cyc[0] = cc0;
    assign o_cyc[1] = cc1;
    assign o_cyc[2] = {12'h000, cc2};

    // Configuration of each instance as seen by the model.
    int cfg_n    [NI] = '{4, 4, 1};
    int cfg_hold [NI] = '{10, 3, 0};
    int cfg_stag [NI] = '{2, 0, 1};
    int cfg_run  [NI] = '{45, 5, 0};
    int cfg_per  [NI] = '{0, 1, 1};
    int cfg_max  [NI] = '{1, 3, 0};
    int cfg_cmax [NI] = '{65535, 65535, 15};

    // Model state for each instance:
    //   m_act   - a round is in progress
    //   m_t     - cycles since the round began
    //   m_idle  - cycles spent parked (idle or done)
    bit m_act   [NI];
    int m_t     [NI];
    bit m_done  [NI];
    int m_round [NI];
    int m_idle  [NI];

    int checks   = 0;
    int failures = 0;

    function automatic int eff(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic int rel_len(input int k);
        return (cfg_n[k] - 1) * cfg_stag[k] + 1;
    endfunction

    function automatic int round_len(input int k);
        return eff(cfg_hold[k]) + rel_len(k) + eff(cfg_run[k]) + 1;
    endfunction

    function automatic void model_step(input int k);
        int nr;
        bit again;
        if (rst) begin
            m_act[k] = 1'b0; m_t[k] = 0; m_done[k] = 1'b0; m_round[k] = 0; m_idle[k] = 0;
        end else if (abort) begin
            m_act[k] = 1'b0; m_done[k] = 1'b0; m_idle[k] = 0;
        end else if (!m_act[k]) begin
            if (start) begin
                m_act[k] = 1'b1; m_t[k] = 0; m_round[k] = 0; m_done[k] = 1'b0;
            end else if (m_idle[k] < cfg_cmax[k]) begin
                m_idle[k] = m_idle[k] + 1;
            end
        end else if (m_t[k] == round_len(k) - 1) begin
            nr = m_round[k] + 1;
            again = (cfg_per[k] != 0) && ((cfg_max[k] == 0) || (nr < cfg_max[k]));
            m_round[k] = nr % 256;
            if (again) begin
                m_t[k] = 0;
            end else begin
                m_act[k] = 1'b0; m_done[k] = 1'b1; m_idle[k] = 0;
            end
        end else begin
            m_t[k] = m_t[k] + 1;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        for (int k = 0; k < NI; k++) begin
            int ones, h, rl, rn, d, e_ch, e_cyc;
            bit e_run;
            ones = (1 << cfg_n[k]) - 1;
            h  = eff(cfg_hold[k]);
            rl = rel_len(k);
            rn = eff(cfg_run[k]);
            e_ch = ones; e_run = 1'b0; e_cyc = 0;
            if (!m_act[k]) begin
                e_cyc = m_idle[k];
            end else if (m_t[k] < h) begin
                e_cyc = m_t[k];
            end else if (m_t[k] < h + rl) begin
                d = m_t[k] - h;
                e_ch = 0;
                for (int i = 0; i < cfg_n[k]; i++) begin
                    if (d < i * cfg_stag[k]) e_ch = e_ch | (1 << i);
                end
                e_cyc = d;
                e_run = (d == rl - 1);
            end else if (m_t[k] < h + rl + rn) begin
                e_ch = 0; e_run = 1'b1; e_cyc = m_t[k] - h - rl;
            end
            chk($sformatf("i%0d_ch_rst", k), 32'(o_ch[k]), 32'(e_ch));
            chk($sformatf("i%0d_running", k), 32'(o_run[k]), 32'(e_run));
            chk($sformatf("i%0d_done", k), 32'(o_done[k]), 32'(m_done[k]));
            chk($sformatf("i%0d_round_cnt", k), 32'(o_rc[k]), 32'(m_round[k]));
            chk($sformatf("i%0d_cyc_cnt", k), 32'(o_cyc[k]), 32'(e_cyc));
        end
    endtask

    // One clock: model advances with the DUT edge, outputs compared on the falling edge.
    task automatic cycle();
        @(posedge clk);
        for (int k = 0; k < NI; k++) model_step(k);
        @(negedge clk);
        check_model();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        for (int k = 0; k < NI; k++) begin
            m_act[k] = 1'b0; m_t[k] = 0; m_done[k] = 1'b0; m_round[k] = 0; m_idle[k] = 0;
        end
        @(negedge clk);
        repeat (10) cycle();
        chk("reset_ch_rst", 32'(o_ch[0]), 32'h0F);
        chk("reset_running", 32'(run0), 32'd0);
        chk("reset_done", 32'(dn0), 32'd0);
        chk("reset_round", 32'(rc0), 32'd0);
        chk("reset_cyc", 32'(cc0), 32'd0);

        // Default sequence: start at cycle 0.
        rst = 1'b0; start = 1'b1;
        cycle();
        start = 1'b0;
        chk("c1_hold_ch", 32'(o_ch[0]), 32'h0F);
        chk("c1_hold_cyc", 32'(cc0), 32'd0);
        repeat (9) cycle();
        chk("c10_hold_cyc", 32'(cc0), 32'd9);
        cycle();
        chk("c11_ch0_rel", 32'(o_ch[0]), 32'h0E);
        repeat (2) cycle();
        chk("c13_ch1_rel", 32'(o_ch[0]), 32'h0C);
        repeat (2) cycle();
        chk("c15_ch2_rel", 32'(o_ch[0]), 32'h08);
        chk("c15_not_running", 32'(run0), 32'd0);
        repeat (2) cycle();
        chk("c17_all_rel", 32'(o_ch[0]), 32'h00);
        chk("c17_running", 32'(run0), 32'd1);
        repeat (45) cycle();
        chk("c62_running", 32'(run0), 32'd1);
        cycle();
        chk("c63_reassert", 32'(o_ch[0]), 32'h0F);
        chk("c63_not_running", 32'(run0), 32'd0);
        chk("c63_round", 32'(rc0), 32'd0);
        cycle();
        chk("c64_done", 32'(dn0), 32'd1);
        chk("c64_round", 32'(rc0), 32'd1);

        // Abort after ch0 and ch1 are released.
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (13) cycle();
        chk("abort_pre_ch", 32'(o_ch[0]), 32'h0C);
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        chk("abort_ch", 32'(o_ch[0]), 32'h0F);
        chk("abort_running", 32'(run0), 32'd0);
        chk("abort_done", 32'(dn0), 32'd0);
        chk("abort_cyc", 32'(cc0), 32'd0);

        // Start held through the whole run: no restart until DONE.
        start = 1'b1;
        repeat (64) cycle();
        chk("held_done", 32'(dn0), 32'd1);
        chk("held_round", 32'(rc0), 32'd1);
        cycle();
        start = 1'b0;
        chk("restart_done", 32'(dn0), 32'd0);
        chk("restart_round", 32'(rc0), 32'd0);
        chk("restart_cyc", 32'(cc0), 32'd0);

        // rst mid-RUN, 30 cycles into the new sequence.
        repeat (29) cycle();
        chk("pre_rst_running", 32'(run0), 32'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("midrst_ch", 32'(o_ch[0]), 32'h0F);
        chk("midrst_cyc", 32'(cc0), 32'd0);
        chk("midrst_round", 32'(rc0), 32'd0);
        chk("midrst_running", 32'(run0), 32'd0);

        // Randomized traffic, checked against the model every cycle.
        for (int n = 0; n < 3000; n++) begin
            start = ($urandom_range(0, 7) == 0);
            abort = ($urandom_range(0, 199) == 0);
            rst   = ($urandom_range(0, 499) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
